// File: rtl/u_rec_ctrl_if.sv
// Receive-controller bus bundle: receiver inputs, host read handshake and status outputs.
// Latency: n/a (wiring only).
// Backpressure: host pops with rd_reqH only while rd_validH is high; the receiver side has no backpressure.
interface u_rec_ctrl_if #(
  parameter int AW = 3
);
  // Receiver side
  logic [7:0]  rec_dataH;
  logic        rec_readyH;
  logic        rx_enH;
  // Host read side
  logic        rd_reqH;
  logic [7:0]  rd_dataH;
  logic        rd_validH;
  logic [AW:0] fifo_countH;
  // Status
  logic        overrunH;
  logic        clr_ovrH;
  logic [7:0]  glitch_cntH;

  // Driver of the controller (receiver model plus host)
  modport master (
    output rec_dataH, rec_readyH, rx_enH, rd_reqH, clr_ovrH,
    input  rd_dataH, rd_validH, fifo_countH, overrunH, glitch_cntH
  );

  // The controller itself
  modport slave (
    input  rec_dataH, rec_readyH, rx_enH, rd_reqH, clr_ovrH,
    output rd_dataH, rd_validH, fifo_countH, overrunH, glitch_cntH
  );
endinterface

// File: rtl/u_rec_ctrl.sv
// Qualifies UART receiver frames by low-time, buffers accepted bytes in a FWFT FIFO, tracks overrun/glitches.
// Latency: byte written at end of the capture cycle; rd_validH rises 2 cycles after the ready rise (empty FIFO).
// Backpressure: none toward the receiver; a byte arriving at a full FIFO without a same-cycle pop is dropped and flagged.
module u_rec_ctrl #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int MIN_LOW = 128
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  u_rec_ctrl_if.slave  bus
);

  // low_cnt only needs to reach MIN_LOW, where it parks.
  localparam int LCW = $clog2(MIN_LOW + 1);
  localparam logic [LCW-1:0] LOW_MAX  = LCW'(MIN_LOW);
  localparam logic [LCW-1:0] LOW_ONE  = LCW'(1);
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  state_t          state;
  logic [LCW-1:0]  low_cnt;
  logic [7:0]      glitch_cnt;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_nxt;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            rd_valid;
  logic [7:0]      rd_data;
  logic            overrun;

  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            drop;

  assign bus.glitch_cntH = glitch_cnt;
  assign bus.fifo_countH = count;
  assign bus.rd_validH   = rd_valid;
  assign bus.rd_dataH    = rd_data;
  assign bus.overrunH    = overrun;

  // Push/pop decisions for this cycle; a same-cycle pop frees the slot a full FIFO needs.
  always_comb begin
    push_req   = (state == S_CAPT) && bus.rx_enH;
    pop        = bus.rd_reqH && rd_valid;
    push_ok    = push_req && ((count < CNT_FULL) || pop);
    drop       = push_req && !push_ok;
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Frame qualifier: measures how long ready stays low and counts too-short low periods.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      low_cnt    <= '0;
      glitch_cnt <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.rec_readyH) begin
            state   <= S_BUSY;
            low_cnt <= LOW_ONE;
          end
        end
        S_BUSY: begin
          if (!bus.rec_readyH) begin
            if (low_cnt != LOW_MAX) begin
              low_cnt <= low_cnt + 1'b1;
            end
          end else if (low_cnt >= LOW_MAX) begin
            state <= S_CAPT;
          end else begin
            if (glitch_cnt != 8'hFF) begin
              glitch_cnt <= glitch_cnt + 1'b1;
            end
            state <= S_IDLE;
          end
        end
        S_CAPT: begin
          // A new frame may already have started while we were capturing.
          if (!bus.rec_readyH) begin
            state   <= S_BUSY;
            low_cnt <= LOW_ONE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO control: pointers, occupancy, registered head view and sticky overrun.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      // Head register follows the next read pointer; bypass when that slot is being written now.
      if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
        rd_data <= bus.rec_dataH;
      end else begin
        rd_data <= mem[rd_ptr_nxt];
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (bus.clr_ovrH) begin
        overrun <= 1'b0;
      end
    end
  end

  // Storage array; contents deliberately survive reset, only the pointers are cleared.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.rec_dataH;
    end
  end

endmodule

// File: tb/tb_u_rec_ctrl.sv
// Directed bench for u_rec_ctrl: frame qualification, FIFO fill/drain/wrap, overrun, glitch saturation, reset.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Expected values are hand-derived constants.
module tb_u_rec_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  u_rec_ctrl_if #(.AW(3)) bus ();

  u_rec_ctrl #(.DEPTH(8), .AW(3), .MIN_LOW(128)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #2;
    sys_rst = 1'b0;
    tick();
  endtask

  // Hold ready low for n edges with data on the bus, then raise ready (no edge consumed after the rise).
  task automatic frame(input int n, input logic [7:0] d);
    bus.rec_dataH  = d;
    bus.rec_readyH = 1'b0;
    repeat (n) tick();
    bus.rec_readyH = 1'b1;
  endtask

  // Qualified frame followed by the two edges that move it into the FIFO.
  task automatic byte_in(input logic [7:0] d);
    frame(130, d);
    tick();
    tick();
  endtask

  task automatic pop_one();
    bus.rd_reqH = 1'b1;
    tick();
    bus.rd_reqH = 1'b0;
  endtask

  initial begin
    bus.rec_dataH  = 8'h00;
    bus.rec_readyH = 1'b1;
    bus.rx_enH     = 1'b1;
    bus.rd_reqH    = 1'b0;
    bus.clr_ovrH   = 1'b0;
    #3;
    chk("rst_valid",   32'(bus.rd_validH),   32'd0);
    chk("rst_data",    32'(bus.rd_dataH),    32'h00);
    chk("rst_count",   32'(bus.fifo_countH), 32'd0);
    chk("rst_overrun", 32'(bus.overrunH),    32'd0);
    chk("rst_glitch",  32'(bus.glitch_cntH), 32'd0);
    sys_rst = 1'b0;
    tick();

    // Single qualified byte, capture latency and pop.
    frame(144, 8'hA5);
    tick();
    chk("lat_valid_1cyc", 32'(bus.rd_validH), 32'd0);
    tick();
    chk("lat_valid_2cyc", 32'(bus.rd_validH),   32'd1);
    chk("first_data",     32'(bus.rd_dataH),    32'hA5);
    chk("first_count",    32'(bus.fifo_countH), 32'd1);
    pop_one();
    chk("pop_valid", 32'(bus.rd_validH),   32'd0);
    chk("pop_count", 32'(bus.fifo_countH), 32'd0);
    pop_one();
    chk("empty_pop_count", 32'(bus.fifo_countH), 32'd0);

    // Threshold boundary: 127 low cycles is a glitch, 128 is a byte.
    frame(127, 8'h11);
    tick();
    tick();
    chk("low127_count",  32'(bus.fifo_countH), 32'd0);
    chk("low127_glitch", 32'(bus.glitch_cntH), 32'd1);
    frame(128, 8'h22);
    tick();
    tick();
    chk("low128_count", 32'(bus.fifo_countH), 32'd1);
    chk("low128_data",  32'(bus.rd_dataH),    32'h22);
    pop_one();

    // False starts and saturation of the glitch counter.
    do_reset();
    frame(5, 8'h99);
    tick();
    tick();
    chk("glitch_one",   32'(bus.glitch_cntH), 32'd1);
    chk("glitch_count", 32'(bus.fifo_countH), 32'd0);
    for (int i = 0; i < 299; i++) begin
      frame(5, 8'h99);
      tick();
    end
    chk("glitch_sat", 32'(bus.glitch_cntH), 32'd255);

    // Nine bytes into an 8-deep FIFO: ninth is lost and overrun sets.
    do_reset();
    for (int i = 1; i <= 8; i++) byte_in(8'(i));
    chk("full_count",      32'(bus.fifo_countH), 32'd8);
    chk("full_no_overrun", 32'(bus.overrunH),    32'd0);
    byte_in(8'h09);
    chk("ovr_count", 32'(bus.fifo_countH), 32'd8);
    chk("ovr_flag",  32'(bus.overrunH),    32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(bus.rd_dataH), 32'(i));
      pop_one();
    end
    chk("drain_valid", 32'(bus.rd_validH),   32'd0);
    chk("drain_count", 32'(bus.fifo_countH), 32'd0);
    chk("ovr_sticky",  32'(bus.overrunH),    32'd1);
    bus.clr_ovrH = 1'b1;
    tick();
    bus.clr_ovrH = 1'b0;
    chk("ovr_clear", 32'(bus.overrunH), 32'd0);

    // Full FIFO with a pop during the capture cycle: byte accepted after pointer wrap.
    for (int i = 0; i < 8; i++) byte_in(8'h10 + 8'(i));
    chk("refill_count", 32'(bus.fifo_countH), 32'd8);
    frame(130, 8'h55);
    tick();
    chk("capt_head", 32'(bus.rd_dataH), 32'h10);
    pop_one();
    chk("pp_count",   32'(bus.fifo_countH), 32'd8);
    chk("pp_overrun", 32'(bus.overrunH),    32'd0);
    chk("pp_head",    32'(bus.rd_dataH),    32'h11);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("wrap_%0d", i), 32'(bus.rd_dataH), 32'h10 + 32'(i));
      pop_one();
    end
    chk("wrap_last", 32'(bus.rd_dataH), 32'h55);
    pop_one();
    chk("wrap_empty", 32'(bus.fifo_countH), 32'd0);

    // Push and pop at occupancy one: head shows the new byte next cycle.
    byte_in(8'h66);
    frame(130, 8'h67);
    tick();
    pop_one();
    chk("one_pp_count", 32'(bus.fifo_countH), 32'd1);
    chk("one_pp_data",  32'(bus.rd_dataH),    32'h67);
    pop_one();

    // Capture disabled: qualified byte discarded quietly.
    bus.rx_enH = 1'b0;
    byte_in(8'h3C);
    bus.rx_enH = 1'b1;
    chk("dis_count",   32'(bus.fifo_countH), 32'd0);
    chk("dis_overrun", 32'(bus.overrunH),    32'd0);
    chk("dis_glitch",  32'(bus.glitch_cntH), 32'd0);

    // Reset in the middle of a frame with data already buffered.
    byte_in(8'h77);
    chk("pre_rst_count", 32'(bus.fifo_countH), 32'd1);
    bus.rec_dataH  = 8'h88;
    bus.rec_readyH = 1'b0;
    repeat (60) tick();
    sys_rst = 1'b1;
    #2;
    chk("mid_rst_count", 32'(bus.fifo_countH), 32'd0);
    chk("mid_rst_valid", 32'(bus.rd_validH),   32'd0);
    sys_rst = 1'b0;
    repeat (40) tick();
    bus.rec_readyH = 1'b1;
    tick();
    tick();
    chk("tail_glitch", 32'(bus.glitch_cntH), 32'd1);
    chk("tail_count",  32'(bus.fifo_countH), 32'd0);
    chk("tail_valid",  32'(bus.rd_validH),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/u_rec_ctrl.md
Name: u_rec_ctrl

Overview:
Receive-side controller that sequences the UART byte receiver (u_rec) and buffers its output.
- Watches the receiver's ready/data outputs.
- Qualifies each completed frame by how long ready stayed low, which rejects false-start glitches.
- Writes accepted bytes into a first-word-fall-through FIFO.
- Presents a valid/req read handshake to the host logic.
- Reports overrun and glitch statistics.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
AW, 3, pointer width = log2(DEPTH)
MIN_LOW, 128, minimum cycles rec_readyH must stay low for the rising edge to count as a real byte (8 bits x 16 clocks)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous reset, active-high
rec_dataH  in  8  received byte from receiver, stable while rec_readyH high
rec_readyH  in  1  receiver ready: low while a frame is in progress, high when idle/done
rx_enH  in  1  capture enable; when low, qualified bytes are discarded
rd_reqH  in  1  host pop request
rd_dataH  out  8  FIFO head byte
rd_validH  out  1  FIFO not empty
fifo_countH  out  AW+1  current occupancy, 0..DEPTH
overrunH  out  1  sticky: qualified byte dropped because FIFO full
clr_ovrH  in  1  clears overrunH
glitch_cntH  out  8  saturating count of rejected short low periods

Behaviour:
- Single clock domain; all state updates on posedge sys_clk; sys_rst asynchronous, active-high.
- Reset values: state S_IDLE, low_cnt 0, pointers 0, fifo_countH 0, rd_validH 0, rd_dataH 8'h00, overrunH 0, glitch_cntH 0.
- low_cnt has width ceil(log2(MIN_LOW+1)) and saturates at MIN_LOW.
- State machine, three states:
  - S_IDLE: if rec_readyH==0, go to S_BUSY and set low_cnt<=1; otherwise stay.
  - S_BUSY: if rec_readyH==0, low_cnt<=sat(low_cnt+1) and stay. If rec_readyH==1 and low_cnt>=MIN_LOW, go to S_CAPT. If rec_readyH==1 and low_cnt<MIN_LOW, glitch_cntH<=sat(glitch_cntH+1) (holds at 255) and go to S_IDLE.
  - S_CAPT (one cycle): sample rec_dataH and issue push if rx_enH==1. Then, if rec_readyH==0, go to S_BUSY with low_cnt<=1; else go to S_IDLE.
  - Unused encodings return to S_IDLE.
- Capture latency: byte is written at the end of the S_CAPT cycle. rd_validH rises 2 cycles after the rec_readyH rising edge is sampled, when the FIFO was empty.
- Push rules:
  - Push is accepted if fifo_countH<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrunH<=1.
  - rx_enH==0 in S_CAPT: byte silently discarded; no overrun.
- Pop rules:
  - Pop occurs when rd_reqH && rd_validH.
  - rd_reqH while empty is ignored; no pointer or count change.
  - rd_dataH always shows mem[rd_ptr]; after a pop it shows the next entry in the next cycle.
- Simultaneous push and pop: count unchanged, both pointers advance. This holds when full and when holding a single entry; at count 1, rd_dataH shows the new byte next cycle.
- Pointers are AW bits and wrap modulo DEPTH. Count saturates logically at DEPTH, never exceeds it.
- overrunH: set has priority over clr_ovrH in the same cycle; otherwise clr_ovrH clears it next cycle.
- Reset mid-frame: all state is lost. If rec_readyH is still low after release, the FSM enters S_BUSY with low_cnt 1. The tail of that frame is shorter than MIN_LOW unless it genuinely exceeds it, so it is counted as a glitch. FIFO contents are discarded.
- FIFO memory is not reset; only pointers and count are.

Test Plan:
- Reset, then rec_readyH low 144 cycles, rec_dataH=8'hA5, then high -> rd_validH=1 two cycles after the rise, rd_dataH=8'hA5, fifo_countH=1; rd_reqH 1 cycle -> rd_validH=0, count 0.
- rec_readyH low 5 cycles then high (false start) -> no push, glitch_cntH=1; repeat 300 times -> glitch_cntH saturates at 255.
- 9 qualified bytes 8'h01..8'h09, no reads, DEPTH=8 -> count=8, overrunH=1, reads return 01..08, 09 lost; clr_ovrH -> overrunH=0.
- FIFO full, rd_reqH asserted in the S_CAPT cycle of byte 8'h55 -> no overrun, count stays 8, 8'h55 read last after wrap of pointers.
- rx_enH=0 during a qualified byte 8'h3C -> count 0, overrunH 0, glitch_cntH unchanged.
- sys_rst pulsed at low_cnt=60 of a frame, released with rec_readyH still low 40 more cycles -> no push, glitch_cntH=1, fifo_countH=0.
